// File: rtl/gate_net_infer_driver.sv
// Byte-stream front end for a combinational gate-network classifier: loads, settles, captures, returns result.
// Optional MTNCL_NULL_PHASE_EN inserts an all-zero NULL spacer of NULL_CYCLES clocks after each result.
module gate_net_infer_driver #(
   parameter int N_IN          = 113,
   parameter int N_OUT         = 2,
   parameter int SETTLE_CYCLES = 2,
   parameter int NULL_CYCLES   = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [7:0]       s_data,
   input  logic             s_last,
   output logic [N_IN-1:0]  net_in_bits,
   input  logic [N_OUT-1:0] net_out_bits,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [N_OUT-1:0] m_class,
   output logic             m_err,
   output logic [15:0]      vec_count
);

   localparam int BEATS   = (N_IN + 7) / 8;
   localparam int BW      = (BEATS < 2) ? 1 : $clog2(BEATS);
   localparam int CNT_MAX = (SETTLE_CYCLES > NULL_CYCLES) ? SETTLE_CYCLES : NULL_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

`ifdef MTNCL_NULL_PHASE_EN
   typedef enum logic [1:0] {ST_LOAD, ST_SETTLE, ST_OUTPUT, ST_NULL} state_t;
`else
   typedef enum logic [1:0] {ST_LOAD, ST_SETTLE, ST_OUTPUT} state_t;
`endif

   state_t             r_state, w_next;
   logic [BW-1:0]      r_beat;
   logic [CNT_W-1:0]   r_cnt;
   logic [N_IN-1:0]    r_net;
   logic [N_OUT-1:0]   r_class;
   logic               r_err;
   logic [15:0]        r_count;
   logic               r_s_ready;
   logic               r_m_valid;
   logic               w_accept, w_end, w_capture, w_hs;
   logic [N_IN-1:0]    w_sel, w_val;

   // Lane steering: the current beat owns bits [8*beat +: 8]; bits past N_IN simply never exist.
   always_comb begin
      w_sel = '0;
      w_val = '0;
      for (int i = 0; i < N_IN; i++) begin
         w_sel[i] = ((i / 8) == int'(r_beat));
         w_val[i] = s_data[3'(i % 8)];
      end
   end

   always_comb begin
      w_next    = r_state;
      w_accept  = 1'b0;
      w_end     = 1'b0;
      w_capture = 1'b0;
      w_hs      = 1'b0;
      case (r_state)
         ST_LOAD: begin
            if (s_valid) begin
               w_accept = 1'b1;
               if (s_last || (r_beat == LAST_BEAT)) begin
                  w_end  = 1'b1;
                  w_next = ST_SETTLE;
               end
            end
         end
         ST_SETTLE: begin
            if (r_cnt == CNT_W'(SETTLE_CYCLES)) begin
               w_capture = 1'b1;
               w_next    = ST_OUTPUT;
            end
         end
         ST_OUTPUT: begin
            if (m_ready) begin
               w_hs = 1'b1;
`ifdef MTNCL_NULL_PHASE_EN
               w_next = ST_NULL;
`else
               w_next = ST_LOAD;
`endif
            end
         end
`ifdef MTNCL_NULL_PHASE_EN
         ST_NULL: begin
            if (r_cnt == CNT_W'(NULL_CYCLES - 1)) w_next = ST_LOAD;
         end
`endif
         default: w_next = ST_LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= ST_LOAD;
         r_beat    <= '0;
         r_cnt     <= '0;
         r_net     <= '0;
         r_class   <= '0;
         r_err     <= 1'b0;
         r_count   <= '0;
         r_s_ready <= 1'b1;
         r_m_valid <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_s_ready <= (w_next == ST_LOAD);
         r_m_valid <= (w_next == ST_OUTPUT);
         if (w_next != r_state) r_cnt <= '0;
         else if (r_state != ST_LOAD && r_state != ST_OUTPUT) r_cnt <= r_cnt + 1'b1;
         if (w_accept) begin
            r_net  <= (r_net & ~w_sel) | (w_val & w_sel);
            r_beat <= w_end ? '0 : r_beat + 1'b1;
         end
         // Framing is wrong whenever s_last and the final beat disagree.
         if (w_end) r_err <= (s_last != (r_beat == LAST_BEAT));
         if (w_capture) r_class <= net_out_bits;
         if (w_hs) begin
            r_count <= r_count + 1'b1;
            r_net   <= '0;
            r_err   <= 1'b0;
         end
      end
   end

   assign s_ready     = r_s_ready;
   assign m_valid     = r_m_valid;
   assign net_in_bits = r_net;
   assign m_class     = r_class;
   assign m_err       = r_err;
   assign vec_count   = r_count;

endmodule

// File: tb/tb_gate_net_infer_driver.sv
// Directed bench for gate_net_infer_driver; the classifier is a tiny behavioural stand-in.
module tb_gate_net_infer_driver;

   localparam int N_IN = 113;
   localparam int N_OUT = 2;
   localparam int SETTLE = 2;
`ifdef MTNCL_NULL_PHASE_EN
   localparam int NULLC = 2;
`else
   localparam int NULLC = 1;
`endif

   logic             clk = 1'b0;
   logic             rst_n;
   logic             s_valid;
   logic             s_ready;
   logic [7:0]       s_data;
   logic             s_last;
   logic [N_IN-1:0]  net_in_bits;
   logic [N_OUT-1:0] net_out_bits;
   logic             m_valid;
   logic             m_ready;
   logic [N_OUT-1:0] m_class;
   logic             m_err;
   logic [15:0]      vec_count;

   int checks = 0;
   int errors = 0;

   gate_net_infer_driver #(
      .N_IN(N_IN), .N_OUT(N_OUT), .SETTLE_CYCLES(SETTLE), .NULL_CYCLES(NULLC)
   ) dut (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .s_last(s_last), .net_in_bits(net_in_bits), .net_out_bits(net_out_bits),
      .m_valid(m_valid), .m_ready(m_ready), .m_class(m_class), .m_err(m_err),
      .vec_count(vec_count)
   );

   // Stand-in classifier: bit0 = in[107] | in[90], bit1 = in[0].
   assign net_out_bits = {net_in_bits[0], net_in_bits[107] | net_in_bits[90]};

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] d, input logic last);
      int n;
      n = 0;
      s_valid = 1'b1;
      s_data  = d;
      s_last  = last;
      while (!s_ready && n < 50) begin
         step();
         n++;
      end
      check("send_ready", n < 50, 1'b1);
      step();
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic expect_result(input string tag, input logic [1:0] cls, input logic err);
      for (int i = 1; i <= SETTLE + 1; i++) begin
         step();
         check({tag, "_lat"}, m_valid, (i == SETTLE + 1));
      end
      check({tag, "_class"}, m_class, cls);
      check({tag, "_err"}, m_err, err);
   endtask

   task automatic handshake(input string tag, input logic [15:0] cnt);
      m_ready = 1'b1;
      step();
      m_ready = 1'b0;
      check({tag, "_cnt"}, vec_count, cnt);
      check({tag, "_mvalid"}, m_valid, 1'b0);
      check({tag, "_net0"}, net_in_bits, '0);
      check({tag, "_err0"}, m_err, 1'b0);
`ifdef MTNCL_NULL_PHASE_EN
      for (int i = 0; i < NULLC; i++) begin
         check({tag, "_null_rdy"}, s_ready, 1'b0);
         check({tag, "_null_net"}, net_in_bits, '0);
         step();
      end
`endif
      check({tag, "_sready"}, s_ready, 1'b1);
   endtask

   initial begin
      logic [N_IN-1:0] ones;
      ones    = '1;
      rst_n   = 1'b0;
      s_valid = 1'b1;
      s_data  = 8'hFF;
      s_last  = 1'b0;
      m_ready = 1'b0;
      repeat (3) step();
      check("rst_sready", s_ready, 1'b1);
      check("rst_mvalid", m_valid, 1'b0);
      check("rst_count", vec_count, 16'd0);
      check("rst_net", net_in_bits, '0);
      rst_n   = 1'b1;
      s_valid = 1'b0;
      step();

      // Nominal full vector of 0xFF.
      for (int k = 0; k < 15; k++) send(8'hFF, k == 14);
      check("nom_net", net_in_bits, ones);
      expect_result("nom", 2'b11, 1'b0);
      handshake("nom_hs", 16'd1);

      // Short vector.
      send(8'h01, 1'b0);
      send(8'h00, 1'b0);
      send(8'h80, 1'b1);
      check("short_net", net_in_bits, 113'h80_0001);
      expect_result("short", 2'b10, 1'b1);
      handshake("short_hs", 16'd2);

      // Missing s_last: 15 bytes close the vector, bytes 16/17 start the next.
      for (int k = 1; k <= 15; k++) send(8'(k), 1'b0);
      check("nolast_net", net_in_bits, 113'h1_0E0D_0C0B_0A09_0807_0605_0403_0201);
      expect_result("nolast", 2'b11, 1'b1);
      handshake("nolast_hs", 16'd3);
      send(8'h10, 1'b0);
      send(8'h11, 1'b1);
      check("carry_net", net_in_bits, 113'h1110);
      expect_result("carry", 2'b00, 1'b1);
      handshake("carry_hs", 16'd4);

      // Back-pressure.
      send(8'hFF, 1'b1);
      expect_result("bp", 2'b10, 1'b1);
      s_valid = 1'b1;
      s_data  = 8'h55;
      for (int i = 0; i < 10; i++) begin
         step();
         check("bp_sready", s_ready, 1'b0);
         check("bp_mvalid", m_valid, 1'b1);
         check("bp_class", m_class, 2'b10);
         check("bp_count", vec_count, 16'd4);
      end
      s_valid = 1'b0;
      handshake("bp_hs", 16'd5);

      // Reset during SETTLE.
      send(8'hFF, 1'b1);
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("rs_sready", s_ready, 1'b1);
      check("rs_mvalid", m_valid, 1'b0);
      check("rs_net", net_in_bits, '0);
      check("rs_count", vec_count, 16'd0);
      for (int i = 0; i < 4; i++) begin
         step();
         check("rs_no_mvalid", m_valid, 1'b0);
      end

      // Reset mid-vector discards the partial vector and beat position.
      send(8'hAA, 1'b0);
      send(8'hAA, 1'b0);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("rv_net", net_in_bits, '0);
      send(8'h80, 1'b1);
      check("rv_net2", net_in_bits, 113'h80);
      expect_result("rv", 2'b00, 1'b1);
      handshake("rv_hs", 16'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
